writeback_regfile: RTL and testbench
====================================

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 Parameter CNT_W, default 16, sets the width of the retired-write counter.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 ALUOut  input  32  write-back data from the stage-3 pipeline register.
REQ-005 S3_WriteSelect  input  5  destination register index for the write-back.
REQ-006 S3_WriteEnable  input  1  write-back request qualifier.
REQ-007 S2_WriteSelect  input  5  destination index of the instruction currently in stage 2.
REQ-008 S2_WriteEnable  input  1  stage-2 write-pending qualifier.
REQ-009 ReadSelect1  input  5  source index, read port 1.
REQ-010 ReadSelect2  input  5  source index, read port 2.
REQ-011 ReadData1  output  32  data for ReadSelect1.
REQ-012 ReadData2  output  32  data for ReadSelect2.
REQ-013 Stall  output  1  read-after-write hazard against stage 2.
REQ-014 WriteCount  output  CNT_W  number of retired register writes.

Function
REQ-015 The block SHALL hold 32 registers of 32 bits, indexed 0-31.
REQ-016 Register 0 SHALL always read 32'h0; writes addressed to index 0 are discarded and not counted.
REQ-017 On posedge clk with rst=0, S3_WriteEnable=1 and S3_WriteSelect!=0, register[S3_WriteSelect] SHALL take ALUOut.
REQ-018 ReadData1/2 SHALL be combinational from ReadSelect1/2 with zero-cycle latency.
REQ-019 Write-through bypass: when S3_WriteEnable=1, S3_WriteSelect!=0 and ReadSelectN==S3_WriteSelect, ReadDataN SHALL equal ALUOut in the same cycle.
REQ-020 Both read ports SHALL bypass independently; equal ReadSelect1 and ReadSelect2 SHALL return identical data.
REQ-021 Stall SHALL be 1 iff S2_WriteEnable=1, S2_WriteSelect!=0, and S2_WriteSelect equals ReadSelect1 or ReadSelect2; otherwise 0.
REQ-022 Stall SHALL NOT depend on stage-3 inputs; stage-3 hazards are resolved by the bypass only.
REQ-023 WriteCount SHALL increment by 1 on each posedge clk that performs a write per REQ-017.
REQ-024 WriteCount SHALL wrap from all-ones to 0 without saturating or flagging.
REQ-025 Repeated writes to the same index on consecutive cycles SHALL each take effect and each be counted.

Reset
REQ-026 On posedge clk with rst=1, all 32 registers SHALL clear to 32'h0 and WriteCount SHALL clear to 0.
REQ-027 rst SHALL take priority over a simultaneous write; that write SHALL be lost and not counted.
REQ-028 During rst=1, ReadData1/2 SHALL still follow REQ-018/REQ-019 combinationally, and Stall SHALL follow REQ-021.
REQ-029 Reset asserted mid-sequence SHALL discard all prior register contents; no partial state SHALL survive.

Verification
REQ-030 Reset, then write reg 5=32'hDEADBEEF; next cycle ReadSelect1=5 -> ReadData1=32'hDEADBEEF, WriteCount=1.
REQ-031 S3_WriteEnable=1, S3_WriteSelect=7, ALUOut=32'h12345678, ReadSelect2=7 in the same cycle -> ReadData2=32'h12345678 before the clock edge.
REQ-032 Write index 0 with 32'hFFFFFFFF -> ReadData1 for index 0 stays 32'h0 (bypass suppressed) and WriteCount unchanged.
REQ-033 S2_WriteEnable=1, S2_WriteSelect=3, ReadSelect1=3 -> Stall=1; change S2_WriteSelect to 0 -> Stall=0; set S2_WriteEnable=0 with index 3 -> Stall=0.
REQ-034 Preload WriteCount to all-ones via 2^CNT_W-1 writes (or CNT_W=4 build: 15 writes), one more write -> WriteCount=0.
REQ-035 Write reg 9=32'hA5A5A5A5, assert rst with a simultaneous write to reg 9 of 32'h1 -> after the edge reg 9 reads 32'h0 and WriteCount=0.

Source files
------------

// File: rtl/writeback_regfile.sv
// 32x32 register file with write-through bypass on both read ports, a
// stage-2 read-after-write stall detector and a wrapping retired-write counter.
module writeback_regfile #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ALUOut,
    input  logic [4:0]       S3_WriteSelect,
    input  logic             S3_WriteEnable,
    input  logic [4:0]       S2_WriteSelect,
    input  logic             S2_WriteEnable,
    input  logic [4:0]       ReadSelect1,
    input  logic [4:0]       ReadSelect2,
    output logic [31:0]      ReadData1,
    output logic [31:0]      ReadData2,
    output logic             Stall,
    output logic [CNT_W-1:0] WriteCount
);

    logic [31:0]      regs_q [32];
    logic [31:0]      regs_d [32];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             wr_hit;

    // Index 0 is never a real write, so it is neither stored, bypassed nor counted.
    assign wr_hit = S3_WriteEnable && (S3_WriteSelect != 5'd0);

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            regs_d[i] = regs_q[i];
        end
        count_d = count_q;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_d[i] = 32'h0;
            end
            count_d = '0;
        end else if (wr_hit) begin
            regs_d[S3_WriteSelect] = ALUOut;
            count_d                = count_q + 1'b1;
        end
        regs_d[0] = 32'h0;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 32; i++) begin
            regs_q[i] <= regs_d[i];
        end
        count_q <= count_d;
    end

    always_comb begin
        if (ReadSelect1 == 5'd0)
            ReadData1 = 32'h0;
        else if (wr_hit && (ReadSelect1 == S3_WriteSelect))
            ReadData1 = ALUOut;
        else
            ReadData1 = regs_q[ReadSelect1];

        if (ReadSelect2 == 5'd0)
            ReadData2 = 32'h0;
        else if (wr_hit && (ReadSelect2 == S3_WriteSelect))
            ReadData2 = ALUOut;
        else
            ReadData2 = regs_q[ReadSelect2];
    end

    // Stage-3 hazards are covered by the bypass; only stage 2 can stall.
    assign Stall = S2_WriteEnable && (S2_WriteSelect != 5'd0) &&
                   ((S2_WriteSelect == ReadSelect1) || (S2_WriteSelect == ReadSelect2));

    assign WriteCount = count_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile built with a 4-bit counter so wrap is reachable.
module tb_writeback_regfile;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      ALUOut;
    logic [4:0]       S3_WriteSelect;
    logic             S3_WriteEnable;
    logic [4:0]       S2_WriteSelect;
    logic             S2_WriteEnable;
    logic [4:0]       ReadSelect1;
    logic [4:0]       ReadSelect2;
    logic [31:0]      ReadData1;
    logic [31:0]      ReadData2;
    logic             Stall;
    logic [CNT_W-1:0] WriteCount;

    int n_cmp = 0;
    int n_err = 0;

    writeback_regfile #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .ALUOut         (ALUOut),
        .S3_WriteSelect (S3_WriteSelect),
        .S3_WriteEnable (S3_WriteEnable),
        .S2_WriteSelect (S2_WriteSelect),
        .S2_WriteEnable (S2_WriteEnable),
        .ReadSelect1    (ReadSelect1),
        .ReadSelect2    (ReadSelect2),
        .ReadData1      (ReadData1),
        .ReadData2      (ReadData2),
        .Stall          (Stall),
        .WriteCount     (WriteCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] idx, input logic [31:0] data);
        S3_WriteEnable = 1'b1;
        S3_WriteSelect = idx;
        ALUOut         = data;
        tick();
        S3_WriteEnable = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ALUOut = '0; S3_WriteSelect = '0; S3_WriteEnable = 1'b0;
        S2_WriteSelect = '0; S2_WriteEnable = 1'b0; ReadSelect1 = '0; ReadSelect2 = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("reset_count", {28'h0, WriteCount}, 32'h0);
        ReadSelect1 = 5'd5; ReadSelect2 = 5'd31; #1;
        chk("reset_rd1_r5", ReadData1, 32'h0);
        chk("reset_rd2_r31", ReadData2, 32'h0);
        chk("reset_stall", {31'h0, Stall}, 32'h0);

        // Basic write then read
        wr(5'd5, 32'hDEADBEEF);
        ReadSelect1 = 5'd5; #1;
        chk("write_r5", ReadData1, 32'hDEADBEEF);
        chk("count_after_1", {28'h0, WriteCount}, 32'h1);

        // Same-cycle bypass on both ports
        S3_WriteEnable = 1'b1; S3_WriteSelect = 5'd7; ALUOut = 32'h12345678;
        ReadSelect1 = 5'd7; ReadSelect2 = 5'd7; #1;
        chk("bypass_rd2", ReadData2, 32'h12345678);
        chk("bypass_rd1_same", ReadData1, 32'h12345678);
        ReadSelect1 = 5'd5; #1;
        chk("no_bypass_other", ReadData1, 32'hDEADBEEF);
        tick();
        S3_WriteEnable = 1'b0; ALUOut = 32'h0; #1;
        chk("stored_r7", ReadData2, 32'h12345678);
        chk("count_after_2", {28'h0, WriteCount}, 32'h2);

        // Write to index 0: no bypass, not stored, not counted
        S3_WriteEnable = 1'b1; S3_WriteSelect = 5'd0; ALUOut = 32'hFFFFFFFF;
        ReadSelect1 = 5'd0; #1;
        chk("r0_bypass_suppressed", ReadData1, 32'h0);
        tick();
        S3_WriteEnable = 1'b0; #1;
        chk("r0_after_write", ReadData1, 32'h0);
        chk("count_r0_unchanged", {28'h0, WriteCount}, 32'h2);

        // Stall detection
        S2_WriteEnable = 1'b1; S2_WriteSelect = 5'd3; ReadSelect1 = 5'd3; ReadSelect2 = 5'd9; #1;
        chk("stall_rs1", {31'h0, Stall}, 32'h1);
        ReadSelect1 = 5'd4; ReadSelect2 = 5'd3; #1;
        chk("stall_rs2", {31'h0, Stall}, 32'h1);
        ReadSelect1 = 5'd4; ReadSelect2 = 5'd9; #1;
        chk("stall_nomatch", {31'h0, Stall}, 32'h0);
        S2_WriteSelect = 5'd0; ReadSelect1 = 5'd0; #1;
        chk("stall_idx0", {31'h0, Stall}, 32'h0);
        S2_WriteEnable = 1'b0; S2_WriteSelect = 5'd3; ReadSelect1 = 5'd3; #1;
        chk("stall_we0", {31'h0, Stall}, 32'h0);
        S3_WriteEnable = 1'b1; S3_WriteSelect = 5'd3; ALUOut = 32'h0000_0033; #1;
        chk("stall_ignores_s3", {31'h0, Stall}, 32'h0);
        S3_WriteEnable = 1'b0; S2_WriteSelect = 5'd0;

        // Counter wrap with back-to-back writes to one register (count is 2)
        for (int i = 0; i < 13; i++) wr(5'd10, 32'h100 + i);
        ReadSelect1 = 5'd10; #1;
        chk("count_all_ones", {28'h0, WriteCount}, 32'hF);
        chk("r10_last_of_13", ReadData1, 32'h10C);
        wr(5'd10, 32'hCAFE0000); #1;
        chk("count_wrap", {28'h0, WriteCount}, 32'h0);
        chk("r10_after_wrap", ReadData1, 32'hCAFE0000);

        // Reset beats a simultaneous write and wipes everything
        wr(5'd9, 32'hA5A5A5A5);
        ReadSelect1 = 5'd9; #1;
        chk("r9_written", ReadData1, 32'hA5A5A5A5);
        chk("count_before_rst", {28'h0, WriteCount}, 32'h1);
        rst = 1'b1; S3_WriteEnable = 1'b1; S3_WriteSelect = 5'd9; ALUOut = 32'h1;
        S2_WriteEnable = 1'b1; S2_WriteSelect = 5'd9; #1;
        chk("bypass_during_rst", ReadData1, 32'h1);
        chk("stall_during_rst", {31'h0, Stall}, 32'h1);
        tick();
        rst = 1'b0; S3_WriteEnable = 1'b0; S2_WriteEnable = 1'b0; #1;
        chk("r9_after_rst", ReadData1, 32'h0);
        chk("count_after_rst", {28'h0, WriteCount}, 32'h0);
        ReadSelect1 = 5'd5; ReadSelect2 = 5'd10; #1;
        chk("r5_after_rst", ReadData1, 32'h0);
        chk("r10_after_rst", ReadData2, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
